// File: rtl/sum_accumulator.sv
// sum_accumulator: collects NUM_SAMPLES unsigned sums from the upstream adder and
// presents the frame total over a held valid/ready output.
// Each frame also reports whether its true total exceeded ACC_WIDTH bits.
//
// Optional build macro SUM_ACCUMULATOR_SATURATE_EN:
//   - Defined: on a carry the running total clamps to all-ones.
//   - Undefined: the running total wraps modulo 2^ACC_WIDTH.
module sum_accumulator #(
    parameter int IN_WIDTH    = 9,
    parameter int ACC_WIDTH   = 16,
    parameter int NUM_SAMPLES = 4,
    localparam int CNT_W      = $clog2(NUM_SAMPLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_overflow,
    output logic [CNT_W-1:0]     sample_cnt
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t               state_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 sticky_q;
    logic [ACC_WIDTH-1:0] out_data_q;
    logic                 out_ovf_q;
    logic                 in_ready_q;
    logic                 out_valid_q;

    logic [ACC_WIDTH:0]   sum_full;
    logic [ACC_WIDTH-1:0] acc_d;
    logic                 carry_d;
    logic                 last_d;

    // Reduce the carry-extended sum to ACC_WIDTH bits.
    // Without saturation the sum simply wraps.
    // With saturation, a saturated total stays at all-ones for any later sample.
    // That holds because adding a nonzero sample to all-ones carries again.
    function automatic logic [ACC_WIDTH-1:0] clamp_sum(input logic [ACC_WIDTH:0] s);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        return s[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : s[ACC_WIDTH-1:0];
`else
        return s[ACC_WIDTH-1:0];
`endif
    endfunction

    // Next running total, carry out of ACC_WIDTH, and the final-sample flag.
    always_comb begin
        sum_full = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, in_data};
        carry_d  = sum_full[ACC_WIDTH];
        acc_d    = clamp_sum(sum_full);
        last_d   = (cnt_q == CNT_W'(NUM_SAMPLES - 1));
    end

    // Frame FSM. It accumulates samples in ACC and holds the result in HOLD until taken.
    // The handshake outputs are registered, so ready has no combinational input path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (in_valid) begin
                        if (last_d) begin
                            out_data_q  <= acc_d;
                            out_ovf_q   <= sticky_q | carry_d;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            sticky_q    <= 1'b0;
                            state_q     <= ST_HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            acc_q    <= acc_d;
                            cnt_q    <= cnt_q + CNT_W'(1);
                            sticky_q <= sticky_q | carry_d;
                        end
                    end
                end
                ST_HOLD: begin
                    // out_data is kept after the handshake.
                    // Only the overflow flag is cleared here.
                    if (out_ready) begin
                        state_q     <= ST_ACC;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        out_ovf_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_ACC;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_overflow = out_ovf_q;
    assign sample_cnt   = cnt_q;

endmodule
